bcd_share_arbiter: RTL and testbench
====================================

// Module: bcd_share_arbiter
// PURPOSE
//  Shares one combinational binary-to-BCD converter between N_REQ requesters
//  (score, high score, lives, ...) of the Breakout display path.
//  Grants requests round-robin, drives the converter input from a register,
//  waits SETTLE cycles, then captures the result into a per-channel BCD register.
//  The display logic reads the per-channel registers directly.
// PARAMETERS
//  N_REQ   3   number of requesters (>=1)
//  W       18  binary input width (>=4), matches the converter width
//  BW      W+(W-4)/3+1  BCD result width (derived localparam, not overridable)
//  SETTLE  1   cycles the converter input is held before capture (>=1)
// PORTS
//  clk        in   1          rising-edge clock
//  reset_n    in   1          synchronous active-low reset
//  req_valid  in   N_REQ      per-channel request; held until its req_ready
//  req_bin    in   N_REQ*W    channel i binary value at [i*W +: W]
//  req_ready  out  N_REQ      one-hot accept pulse (combinational, IDLE only)
//  conv_bin   out  W          registered converter input
//  conv_bcd   in   BW         converter output
//  out_bcd    out  N_REQ*BW   channel i result at [i*BW +: BW], held until overwritten
//  done       out  N_REQ      one-cycle pulse: out_bcd of channel i updated
//  busy       out  1          1 while state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE, ptr=0, conv_bin=0, out_bcd=0,
//   done=0, cnt=0; req_ready=0 while reset_n=0. The in-flight conversion is
//   dropped, with no done and no out_bcd write.
//  FSM: IDLE, WAIT.
//   IDLE: g = first i with req_valid[i]=1, searching ptr, ptr+1, ...
//    modulo N_REQ. req_ready[g]=1 this cycle. At the edge:
//    conv_bin<=req_bin[g], gsel<=g, cnt<=SETTLE-1, state->WAIT.
//    No valid: stay in IDLE, req_ready=0.
//   WAIT: req_ready=0. At the edge with cnt!=0: cnt<=cnt-1.
//    At the edge with cnt==0: out_bcd[gsel]<=conv_bcd, done[gsel]<=1,
//    ptr<=(gsel==N_REQ-1)?0:gsel+1, state->IDLE.
//  Latency: accept edge E0; capture at edge E0+SETTLE; done high the cycle after.
//  Throughput: one conversion per SETTLE+1 cycles.
//  done is registered and high for exactly one cycle; all other done bits are 0.
//  req_valid dropped before req_ready: legal, no effect. req_bin is sampled
//   only in the accept cycle; later changes are ignored.
//  req_valid changes during WAIT: no effect until the next IDLE cycle.
//  A channel stays valid after done: re-granted when its turn comes (no starvation).
//  N_REQ=1: ptr stays 0; the channel is granted every IDLE cycle it is valid.
//  conv_bin is widened to BW by the converter; no arithmetic is done here.
// CONFIGURATION
//  BCD_CACHE_EN defined: keep last_bin[i] and a cache-valid bit per channel,
//   both cleared by reset and set on every capture. In IDLE, if the granted
//   channel's req_bin equals last_bin[g] and the cache is valid:
//   req_ready[g]=1, done[g]<=1 at E0, ptr advances, state stays IDLE,
//   conv_bin and out_bcd are unchanged. Latency is 1 cycle.
//  BCD_CACHE_EN undefined: every grant performs a full conversion;
//   no last_bin storage is built.
// TESTING  (N_REQ=3, W=18, SETTLE=1 unless stated; bench models the converter)
//  1. ch0 bin=12345 after reset -> req_ready[0] 1 cycle; out_bcd[0]=0x012345;
//     done[0] in cycle E0+2.
//  2. ch0,1,2 valid together with bins 1,2,3 -> grants 0,1,2; done pulses
//     2 cycles apart; out_bcd = 0x000001, 0x000002, 0x000003.
//  3. ch0 held valid, ch2 held valid -> grant sequence 0,2,0,2; ch1 never granted.
//  4. ch1 bin=262143 -> out_bcd[1]=23'h262143; bin=0 -> 0x000000.
//  5. SETTLE=4, reset_n=0 for 1 cycle during WAIT -> no done; out_bcd all 0;
//     next request granted from ptr=0.
//  6. ch1 requests 999 twice -> second done 1 cycle after accept with
//     BCD_CACHE_EN, 2 cycles without it; out_bcd[1]=0x000999 both times.

Source files
------------

// File: rtl/bcd_share_arbiter_if.sv
// Request/result bundle between the display requesters, the shared binary-to-BCD
// converter and bcd_share_arbiter (the arbiter uses the slave modport).
interface bcd_share_arbiter_if #(
   parameter int N_REQ = 3,
   parameter int W     = 18
);
   localparam int BW = W + (W - 4) / 3 + 1;

   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*W-1:0]  req_bin;
   logic [N_REQ-1:0]    req_ready;
   logic [W-1:0]        conv_bin;
   logic [BW-1:0]       conv_bcd;
   logic [N_REQ*BW-1:0] out_bcd;
   logic [N_REQ-1:0]    done;
   logic                busy;

   modport master (
      output req_valid, req_bin, conv_bcd,
      input  req_ready, conv_bin, out_bcd, done, busy
   );

   modport slave (
      input  req_valid, req_bin, conv_bcd,
      output req_ready, conv_bin, out_bcd, done, busy
   );
endinterface

// File: rtl/bcd_share_arbiter.sv
// Round-robin sharing of one combinational binary-to-BCD converter between N_REQ channels.
// Optional result cache per channel is enabled by defining BCD_CACHE_EN.
module bcd_share_arbiter #(
   parameter int N_REQ  = 3,
   parameter int W      = 18,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   bcd_share_arbiter_if.slave bus
);
   localparam int BW = W + (W - 4) / 3 + 1;
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [PW-1:0] LAST_CH  = PW'(N_REQ - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           r_state, w_state_next;
   logic [PW-1:0]    r_ptr, w_ptr_next;
   logic [PW-1:0]    r_gsel, w_gsel_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic [W-1:0]     r_conv_bin, w_conv_bin_next;
   logic [N_REQ-1:0] r_done, w_done_next;
   logic [BW-1:0]    r_out_bcd [N_REQ];

   logic [W-1:0]     w_bin [N_REQ];
   logic             w_found;
   logic [PW-1:0]    w_gidx;
   logic [N_REQ-1:0] w_gnt_onehot;
   logic             w_capture;
   logic             w_hit;

   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] g);
      return (g == LAST_CH) ? '0 : g + PW'(1);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_chan
         assign w_bin[gi] = bus.req_bin[gi*W +: W];
         assign bus.out_bcd[gi*BW +: BW] = r_out_bcd[gi];

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_out_bcd[gi] <= '0;
            end else if (w_capture && (r_gsel == PW'(gi))) begin
               r_out_bcd[gi] <= bus.conv_bcd;
            end
         end
      end
   endgenerate

   // First valid channel at or after r_ptr, wrapping modulo N_REQ.
   always_comb begin
      logic [PW:0] w_sum;
      w_found = 1'b0;
      w_gidx  = '0;
      w_sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(N_REQ)) begin
            w_sum = w_sum - (PW+1)'(N_REQ);
         end
         if (!w_found && bus.req_valid[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_gidx  = w_sum[PW-1:0];
         end
      end
   end

`ifdef BCD_CACHE_EN
   logic [W-1:0]     r_last_bin [N_REQ];
   logic [N_REQ-1:0] r_cache_vld;

   assign w_hit = w_found && r_cache_vld[w_gidx] && (w_bin[w_gidx] == r_last_bin[w_gidx]);

   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cache
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_last_bin[gi]  <= '0;
               r_cache_vld[gi] <= 1'b0;
            end else if (w_capture && (r_gsel == PW'(gi))) begin
               r_last_bin[gi]  <= r_conv_bin;
               r_cache_vld[gi] <= 1'b1;
            end
         end
      end
   endgenerate
`else
   assign w_hit = 1'b0;
`endif

   always_comb begin
      w_state_next    = r_state;
      w_ptr_next      = r_ptr;
      w_gsel_next     = r_gsel;
      w_cnt_next      = r_cnt;
      w_conv_bin_next = r_conv_bin;
      w_done_next     = '0;
      w_gnt_onehot    = '0;
      w_capture       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_gnt_onehot[w_gidx] = 1'b1;
               if (w_hit) begin
                  // Same value as the last capture: result is already in out_bcd.
                  w_done_next[w_gidx] = 1'b1;
                  w_ptr_next          = f_next_ptr(w_gidx);
               end else begin
                  w_conv_bin_next = w_bin[w_gidx];
                  w_gsel_next     = w_gidx;
                  w_cnt_next      = CNT_LOAD;
                  w_state_next    = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_next = r_cnt - CNT_ONE;
            end else begin
               w_capture           = 1'b1;
               w_done_next[r_gsel] = 1'b1;
               w_ptr_next          = f_next_ptr(r_gsel);
               w_state_next        = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_gsel     <= '0;
         r_cnt      <= '0;
         r_conv_bin <= '0;
         r_done     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_gsel     <= w_gsel_next;
         r_cnt      <= w_cnt_next;
         r_conv_bin <= w_conv_bin_next;
         r_done     <= w_done_next;
      end
   end

   assign bus.req_ready = reset_n ? w_gnt_onehot : '0;
   assign bus.conv_bin  = r_conv_bin;
   assign bus.done      = r_done;
   assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Bench for bcd_share_arbiter: table of single-channel conversions plus
// hand-written multi-channel, fairness and reset-in-flight sequences.
module tb_bcd_share_arbiter;
    localparam int N  = 3;
    localparam int W  = 18;
    localparam int BW = 23;
`ifdef BCD_CACHE_EN
    localparam int LAT_HIT = 1;
`else
    localparam int LAT_HIT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n1;
    logic rst_n2;
    int   total = 0;
    int   bad   = 0;

    bcd_share_arbiter_if #(.N_REQ(N), .W(W)) bus1 ();
    bcd_share_arbiter_if #(.N_REQ(N), .W(W)) bus2 ();

    bcd_share_arbiter #(.N_REQ(N), .W(W), .SETTLE(1)) dut1 (
        .clk     (clk),
        .reset_n (rst_n1),
        .bus     (bus1)
    );

    bcd_share_arbiter #(.N_REQ(N), .W(W), .SETTLE(4)) dut2 (
        .clk     (clk),
        .reset_n (rst_n2),
        .bus     (bus2)
    );

    // Converter model: decimal digits by repeated division.
    function automatic logic [BW-1:0] to_bcd(input logic [W-1:0] b);
        logic [23:0] r;
        int          v;
        r = '0;
        v = int'(b);
        for (int d = 0; d < 6; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r[BW-1:0];
    endfunction

    always_comb bus1.conv_bcd = to_bcd(bus1.conv_bin);
    always_comb bus2.conv_bcd = to_bcd(bus2.conv_bin);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int            ch;
        logic [W-1:0]  bin;
        logic [BW-1:0] bcd;
        int            lat;
    } vec_t;

    vec_t          vecs [9];
    logic [BW-1:0] exp_out1 [N];
    int            q_gnt [$];
    int            q_dch [$];
    int            q_dcyc [$];

    // One request on dut1, dropped after its accept edge; checks ready, latency, results.
    task automatic run_vec(input vec_t v);
        logic [N-1:0] one;
        logic [N-1:0] oh;
        int           lat;
        one = 1;
        oh  = one << v.ch;
        bus1.req_valid = oh;
        bus1.req_bin   = '0;
        bus1.req_bin[v.ch*W +: W] = v.bin;
        #1;
        check("req_ready", bus1.req_ready, oh);
        tick();
        bus1.req_valid = '0;
        bus1.req_bin   = '1;
        check("conv_bin", bus1.conv_bin, v.bin);
        lat = 1;
        while (bus1.done == '0 && lat < 12) begin
            tick();
            lat++;
        end
        check("latency", lat, v.lat);
        check("done_onehot", bus1.done, oh);
        exp_out1[v.ch] = v.bcd;
        for (int c = 0; c < N; c++) begin
            check("out_bcd", bus1.out_bcd[c*BW +: BW], exp_out1[c]);
        end
        check("busy_idle", bus1.busy, 0);
        $display("txn ch=%0d bin=%0d out_bcd=%h latency=%0d", v.ch, v.bin, bus1.out_bcd[v.ch*BW +: BW], lat);
        tick();
        check("done_pulse", bus1.done, 0);
    endtask

    // Run dut1 until 'want' done pulses, logging grants and done cycles.
    task automatic collect(input int want, input bit drop);
        int cyc;
        int g;
        q_gnt.delete();
        q_dch.delete();
        q_dcyc.delete();
        cyc = 0;
        while (q_dch.size() < want && cyc < 40) begin
            #1;
            g = -1;
            for (int c = 0; c < N; c++) if (bus1.req_ready[c]) g = c;
            if (g >= 0) q_gnt.push_back(g);
            for (int c = 0; c < N; c++) begin
                if (bus1.done[c]) begin
                    q_dch.push_back(c);
                    q_dcyc.push_back(cyc);
                end
            end
            tick();
            if (drop && g >= 0) bus1.req_valid[g] = 1'b0;
            cyc++;
        end
        check("seq_done_count", q_dch.size(), want);
    endtask

    initial begin
        int lat;
        int exp3 [4];
        logic [N-1:0] seen;

        vecs[0] = '{0, 18'd12345,  23'h012345, 2};
        vecs[1] = '{1, 18'd262143, 23'h262143, 2};
        vecs[2] = '{1, 18'd0,      23'h000000, 2};
        vecs[3] = '{2, 18'd1,      23'h000001, 2};
        vecs[4] = '{1, 18'd999,    23'h000999, 2};
        vecs[5] = '{1, 18'd999,    23'h000999, LAT_HIT};
        vecs[6] = '{1, 18'd1000,   23'h001000, 2};
        vecs[7] = '{0, 18'd100000, 23'h100000, 2};
        vecs[8] = '{2, 18'd99999,  23'h099999, 2};
        exp3 = '{0, 2, 0, 2};
        for (int c = 0; c < N; c++) exp_out1[c] = '0;

        // Reset with all channels requesting: no ready, everything cleared.
        rst_n1 = 1'b0;
        rst_n2 = 1'b0;
        bus1.req_valid = '1;
        bus1.req_bin   = '1;
        bus2.req_valid = '1;
        bus2.req_bin   = '1;
        tick();
        tick();
        check("rst_ready1", bus1.req_ready, 0);
        check("rst_ready2", bus2.req_ready, 0);
        check("rst_done", bus1.done, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_conv_bin", bus1.conv_bin, 0);
        check("rst_out_bcd", bus1.out_bcd, 0);
        bus1.req_valid = '0;
        bus2.req_valid = '0;
        bus1.req_bin   = '0;
        bus2.req_bin   = '0;
        rst_n1 = 1'b1;
        rst_n2 = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // All three channels at once after reset: grants 0,1,2, done every 2 cycles.
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        bus1.req_bin   = {18'd3, 18'd2, 18'd1};
        bus1.req_valid = 3'b111;
        collect(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < q_gnt.size()) check("seq2_grant", q_gnt[i], i);
            if (i < q_dch.size()) begin
                check("seq2_done_ch", q_dch[i], i);
                check("seq2_done_cyc", q_dcyc[i], 2 + 2 * i);
            end
            check("seq2_out_bcd", bus1.out_bcd[i*BW +: BW], to_bcd(18'(i + 1)));
        end
        $display("txn seq2 grants=%0d dones=%0d", q_gnt.size(), q_dch.size());

        // Channels 0 and 2 held valid: strict alternation, channel 1 idle.
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        bus1.req_bin   = {18'd7, 18'd0, 18'd5};
        bus1.req_valid = 3'b101;
        collect(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i < q_gnt.size()) check("seq3_grant", q_gnt[i], exp3[i]);
        end
        check("seq3_out0", bus1.out_bcd[0 +: BW], 23'h000005);
        check("seq3_out1", bus1.out_bcd[BW +: BW], 23'h000000);
        check("seq3_out2", bus1.out_bcd[2*BW +: BW], 23'h000007);
        $display("txn seq3 grants=%0d dones=%0d", q_gnt.size(), q_dch.size());
        bus1.req_valid = '0;

        // SETTLE=4: full conversion on ch1 moves ptr to 2.
        bus2.req_bin   = '0;
        bus2.req_bin[W +: W] = 18'd10;
        bus2.req_valid = 3'b010;
        #1;
        check("s4_ready_ch1", bus2.req_ready, 3'b010);
        tick();
        bus2.req_valid = '0;
        lat = 1;
        while (bus2.done == '0 && lat < 12) begin
            tick();
            lat++;
        end
        check("s4_latency", lat, 5);
        check("s4_out1", bus2.out_bcd[BW +: BW], 23'h000010);
        $display("txn settle4 ch=1 bin=10 latency=%0d", lat);
        tick();

        // ch2 accepted, then reset mid-WAIT: conversion dropped.
        bus2.req_bin[2*W +: W] = 18'd20;
        bus2.req_valid = 3'b100;
        #1;
        check("s4_ready_ch2", bus2.req_ready, 3'b100);
        tick();
        bus2.req_valid = '0;
        check("s4_busy", bus2.busy, 1);
        tick();
        tick();
        rst_n2 = 1'b0;
        tick();
        rst_n2 = 1'b1;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | bus2.done;
            tick();
        end
        check("s4_no_done", seen, 0);
        check("s4_busy_after_rst", bus2.busy, 0);
        check("s4_conv_bin_rst", bus2.conv_bin, 0);
        check("s4_out_bcd_rst", bus2.out_bcd, 0);

        // Pointer restarted at 0: ch0 wins over ch2.
        bus2.req_bin   = {18'd40, 18'd0, 18'd30};
        bus2.req_valid = 3'b101;
        #1;
        check("s4_ready_ptr0", bus2.req_ready, 3'b001);
        tick();
        bus2.req_valid = '0;
        lat = 1;
        while (bus2.done == '0 && lat < 12) begin
            tick();
            lat++;
        end
        check("s4_latency2", lat, 5);
        check("s4_done_ch0", bus2.done, 3'b001);
        check("s4_out0", bus2.out_bcd[0 +: BW], 23'h000030);
        $display("txn settle4 ch=0 bin=30 latency=%0d", lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
